// File: rtl/uart_frame_pkg.sv
// Shared constants and parser state encoding for the UART frame parser.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } parser_state_t;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle timer: counts cycles while enabled; expired_o pulses on
// the LIMIT-th consecutive cycle without a restart.
module uart_byte_timer #(
  parameter int unsigned LIMIT = 4340
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  // A coinciding restart wins over expiry, so a late byte is still accepted.
  assign expired_o = enable_i && !restart_i && (cnt_q == W'(LIMIT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (restart_i || !enable_i || expired_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SYNC/LEN/payload/CHK frames from a UART byte stream and forwards payload bytes.
// Optional inter-byte timeout is enabled with macro UART_FRAME_TIMEOUT_EN.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 4340
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx_dv_i,
  input  logic [7:0]    rx_byte_i,
  output logic          pl_dv_o,
  output logic [7:0]    pl_byte_o,
  output logic [7:0]    pl_idx_o,
  output logic          frame_ok_o,
  output logic          frame_err_o,
  output parser_state_t state_o
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  parser_state_t state_q, state_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    len_q, len_d;
  logic          pl_dv_q, pl_dv_d;
  logic [7:0]    pl_byte_q, pl_byte_d;
  logic [7:0]    pl_idx_q, pl_idx_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          timeout_expired;

`ifdef UART_FRAME_TIMEOUT_EN
  uart_byte_timer #(
    .LIMIT (TIMEOUT_CLKS)
  ) u_byte_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (rx_dv_i),
    .enable_i  (state_q != ST_IDLE),
    .expired_o (timeout_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CLKS);
  assign timeout_expired    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    pl_dv_d   = 1'b0;
    pl_byte_d = pl_byte_q;
    pl_idx_d  = pl_idx_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;

    if (rx_dv_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_byte_i == SYNC_BYTE) begin
            state_d = ST_LEN;
          end
        end
        ST_LEN: begin
          if ((rx_byte_i == 8'd0) || (rx_byte_i > MAX_LEN_B)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            sum_d   = rx_byte_i;
            len_d   = rx_byte_i;
            cnt_d   = 8'd0;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          pl_dv_d   = 1'b1;
          pl_byte_d = rx_byte_i;
          pl_idx_d  = cnt_q;
          sum_d     = sum_q + rx_byte_i;
          cnt_d     = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (8'(sum_q + rx_byte_i) == 8'd0) begin
            ok_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          sum_d   = 8'd0;
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_expired) begin
      err_d   = 1'b1;
      sum_d   = 8'd0;
      cnt_d   = 8'd0;
      state_d = ST_IDLE;
    end
  end

  // Reset drops any frame in flight without an error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      sum_q     <= 8'd0;
      cnt_q     <= 8'd0;
      len_q     <= 8'd0;
      pl_dv_q   <= 1'b0;
      pl_byte_q <= 8'd0;
      pl_idx_q  <= 8'd0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      pl_dv_q   <= pl_dv_d;
      pl_byte_q <= pl_byte_d;
      pl_idx_q  <= pl_idx_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  assign pl_dv_o     = pl_dv_q;
  assign pl_byte_o   = pl_byte_q;
  assign pl_idx_o    = pl_idx_q;
  assign frame_ok_o  = ok_q;
  assign frame_err_o = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: frame parsing, length bounds, checksum,
// reset mid-frame and (with UART_FRAME_TIMEOUT_EN) inter-byte timeout.
module tb_uart_frame_parser;
  import uart_frame_pkg::*;

  localparam int unsigned MAX_LEN      = 16;
  localparam int unsigned TIMEOUT_CLKS = 4340;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          pl_dv;
  logic [7:0]    pl_byte;
  logic [7:0]    pl_idx;
  logic          frame_ok;
  logic          frame_err;
  parser_state_t state;

  uart_frame_parser #(
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_dv_i     (rx_dv),
    .rx_byte_i   (rx_byte),
    .pl_dv_o     (pl_dv),
    .pl_byte_o   (pl_byte),
    .pl_idx_o    (pl_idx),
    .frame_ok_o  (frame_ok),
    .frame_err_o (frame_err),
    .state_o     (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int ok_cnt = 0, err_cnt = 0, both_cnt = 0, stab_cnt = 0;
  int ok_base = 0, err_base = 0;
  logic [7:0] last_byte = 8'd0, last_idx = 8'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitor: records payload strobes and result pulses on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      last_byte <= 8'd0;
      last_idx  <= 8'd0;
    end else begin
      if (pl_dv) begin
        obs_q.push_back({pl_idx, pl_byte});
        last_byte <= pl_byte;
        last_idx  <= pl_idx;
      end else if (pl_byte !== last_byte || pl_idx !== last_idx) begin
        stab_cnt <= stab_cnt + 1;
      end
      if (frame_ok)              ok_cnt   <= ok_cnt + 1;
      if (frame_err)             err_cnt  <= err_cnt + 1;
      if (frame_ok && frame_err) both_cnt <= both_cnt + 1;
    end
  end

  // driver: one byte strobe; checks the registered outputs one cycle later
  task automatic send_byte(input logic [7:0] b, input logic exp_pl, input logic exp_ok,
                           input logic exp_err);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    check_val("lat_pl_dv", pl_dv, exp_pl);
    check_val("lat_ok", frame_ok, exp_ok);
    check_val("lat_err", frame_err, exp_err);
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_byte = 8'($urandom_range(0, 255));
  endtask

  task automatic send_payload(input logic [7:0] b, input logic [7:0] idx);
    exp_q.push_back({idx, b});
    send_byte(b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int exp_ok, input int exp_err);
    repeat (2) @(negedge clk);
    #1;
    check_val({tag, "_npl"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check_val({tag, "_pl"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
    check_val({tag, "_ok"}, ok_cnt - ok_base, exp_ok);
    check_val({tag, "_err"}, err_cnt - err_base, exp_err);
    ok_base  = ok_cnt;
    err_base = err_cnt;
  endtask

  task automatic good_short_frame(input string tag);
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0, 1'b0);
    send_payload(8'h7F, 8'd0);
    send_byte(8'h80, 1'b0, 1'b1, 1'b0);
    check_frame(tag, 1, 0);
  endtask

  initial begin
    logic [7:0] sum;

    rst     = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_pl_dv", pl_dv, 1'b0);
    check_val("rst_pl_byte", pl_byte, 8'h00);
    check_val("rst_pl_idx", pl_idx, 8'h00);
    check_val("rst_ok", frame_ok, 1'b0);
    check_val("rst_err", frame_err, 1'b0);
    check_val("rst_state", state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // good frame
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0, 1'b0);
    send_payload(8'h11, 8'd0);
    send_payload(8'h22, 8'd1);
    send_payload(8'h33, 8'd2);
    send_byte(8'h97, 1'b0, 1'b1, 1'b0);
    check_frame("good", 1, 0);

    // bad checksum
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0, 1'b0);
    send_payload(8'h11, 8'd0);
    send_payload(8'h22, 8'd1);
    send_payload(8'h33, 8'd2);
    send_byte(8'h98, 1'b0, 1'b0, 1'b1);
    check_frame("badchk", 0, 1);

    // noise, then A5 taken as length; 5A also exceeds MAX_LEN
    send_byte(8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0, 1'b1);
    send_byte(8'h01, 1'b0, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0, 1'b1);
    check_frame("resync", 0, 2);
    good_short_frame("resume");

    // zero length
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0, 1'b1);
    check_frame("len0", 0, 1);

    // LEN = MAX_LEN is accepted
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'(MAX_LEN), 1'b0, 1'b0, 1'b0);
    sum = 8'(MAX_LEN);
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      send_payload(8'(8'h10 + i), 8'(i));
      sum = sum + 8'(8'h10 + i);
    end
    send_byte(8'(8'd0 - sum), 1'b0, 1'b1, 1'b0);
    check_frame("lenmax", 1, 0);

    // LEN = MAX_LEN+1 is rejected
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'(MAX_LEN + 1), 1'b0, 1'b0, 1'b1);
    check_frame("lenover", 0, 1);

    // A5 inside the payload is plain data
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0, 1'b0);
    send_payload(8'hA5, 8'd0);
    send_payload(8'hA5, 8'd1);
    send_byte(8'hB4, 1'b0, 1'b1, 1'b0);
    check_frame("a5data", 1, 0);

`ifdef UART_FRAME_TIMEOUT_EN
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0, 1'b0);
    send_payload(8'h11, 8'd0);
    repeat (TIMEOUT_CLKS - 1) @(negedge clk);
    #1;
    check_val("to_early", err_cnt - err_base, 0);
    check_frame("timeout", 0, 1);
    good_short_frame("after_to");
`else
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0, 1'b0);
    send_payload(8'h11, 8'd0);
    repeat (TIMEOUT_CLKS + 600) @(negedge clk);
    check_frame("longwait", 0, 0);
    send_payload(8'h22, 8'd1);
    send_byte(8'hCB, 1'b0, 1'b1, 1'b0);
    check_frame("wait_done", 1, 0);
`endif

    // reset mid-payload
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0, 1'b0);
    send_payload(8'h01, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mid_rst_pl_dv", pl_dv, 1'b0);
    check_val("mid_rst_pl_byte", pl_byte, 8'h00);
    check_val("mid_rst_pl_idx", pl_idx, 8'h00);
    check_val("mid_rst_ok", frame_ok, 1'b0);
    check_val("mid_rst_err", frame_err, 1'b0);
    check_val("mid_rst_state", state, ST_IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_frame("mid_rst", 0, 0);
    good_short_frame("after_rst");

    repeat (3) @(negedge clk);
    #1;
    check_val("ok_err_overlap", both_cnt, 0);
    check_val("pl_hold_stable", stab_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning the maximum accepted payload length in bytes (1..255).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 4340, meaning the inter-byte timeout in clk_i cycles (20 bit times at 217 clocks per bit).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx_dv_i  input  1  one-cycle strobe from the UART receiver marking a valid received byte.
REQ-006 SHALL have port rx_byte_i  input  8  received byte, valid while rx_dv_i=1.
REQ-007 SHALL have port pl_dv_o  output  1  one-cycle strobe marking a forwarded payload byte.
REQ-008 SHALL have port pl_byte_o  output  8  payload byte, valid while pl_dv_o=1.
REQ-009 SHALL have port pl_idx_o  output  8  zero-based index of the current payload byte.
REQ-010 SHALL have port frame_ok_o  output  1  one-cycle pulse: the frame's checksum matched.
REQ-011 SHALL have port frame_err_o  output  1  one-cycle pulse: the frame was aborted (bad length, bad checksum or timeout).

Function
REQ-012 SHALL use frame format SYNC(0xA5), LEN, LEN payload bytes, CHK, where (LEN + all payload bytes + CHK) mod 256 = 0.
REQ-013 SHALL implement states IDLE, LEN, PAYLOAD and CHECK, and advance only on cycles where rx_dv_i=1.
REQ-014 SHALL, in IDLE, go to LEN on byte 0xA5 and silently discard any other byte.
REQ-015 SHALL, in LEN, abort to IDLE with frame_err_o if LEN=0 or LEN>MAX_LEN; otherwise it SHALL load the 8-bit running sum with LEN and go to PAYLOAD.
REQ-016 SHALL, in PAYLOAD, forward each byte registered (pl_dv_o exactly 1 cycle after rx_dv_i), add it to the sum mod 256, and go to CHECK after byte LEN-1.
REQ-017 SHALL, in CHECK, pulse frame_ok_o when (sum+CHK) mod 256 = 0 and otherwise pulse frame_err_o, 1 cycle after rx_dv_i, then return to IDLE.
REQ-018 SHALL treat a 0xA5 arriving outside IDLE as ordinary data, with no resynchronisation.
REQ-019 SHALL never assert frame_ok_o and frame_err_o in the same cycle.
REQ-020 SHALL hold pl_byte_o and pl_idx_o stable between pl_dv_o strobes.
REQ-021 SHALL require the downstream consumer to discard the buffered payload on frame_err_o, since payload bytes are not retracted.

Reset
REQ-022 SHALL, while rst_i=1, force state IDLE, sum and byte counter to 0, pl_dv_o, frame_ok_o and frame_err_o to 0, and pl_byte_o and pl_idx_o to 0x00.
REQ-023 SHALL, when reset asserts mid-frame, drop the frame with no frame_err_o pulse, and SHALL accept a new SYNC on the first rx_dv_i after release.

Configuration
REQ-024 SHALL, when macro UART_FRAME_TIMEOUT_EN is defined, count clk_i cycles since the last rx_dv_i while in state LEN, PAYLOAD or CHECK.
REQ-025 SHALL, with UART_FRAME_TIMEOUT_EN defined, pulse frame_err_o and return to IDLE when that count reaches TIMEOUT_CLKS.
REQ-026 SHALL, with UART_FRAME_TIMEOUT_EN defined, give rx_dv_i priority when it coincides with timeout expiry: the byte is processed and the counter clears.
REQ-027 SHALL, when UART_FRAME_TIMEOUT_EN is undefined, omit the timeout counter entirely and wait indefinitely in any state.

Structure
REQ-028 SHALL place the SYNC_BYTE constant (0xA5) and the parser state encoding in shared package uart_frame_pkg.
REQ-029 SHALL implement the timeout counter as sub-module uart_byte_timer (inputs: restart, enable; output: one-cycle expired), instantiated only under UART_FRAME_TIMEOUT_EN.

Verification
REQ-030 SHALL verify: A5 03 11 22 33 97 -> pl_dv_o x3 with bytes 11/22/33 and idx 0/1/2, then frame_ok_o=1 for 1 cycle.
REQ-031 SHALL verify: A5 03 11 22 33 98 -> same 3 payload strobes, then frame_err_o=1 and frame_ok_o=0.
REQ-032 SHALL verify: 00 A5 A5 01 A5 5A -> the leading 00 is ignored, the second A5 is taken as LEN=0xA5 > MAX_LEN so frame_err_o pulses, and parsing then resumes.
REQ-033 SHALL verify: A5 00 -> frame_err_o pulses and pl_dv_o is never asserted.
REQ-034 SHALL verify, with UART_FRAME_TIMEOUT_EN defined: A5 02 11 followed by 4340 idle cycles -> frame_err_o pulses, and a following A5 01 7F 80 gives frame_ok_o.
REQ-035 SHALL verify: rst_i asserted mid-payload after A5 04 01 -> all outputs are 0 immediately, no err pulse, and A5 01 7F 80 after release gives frame_ok_o.
